// File: rtl/segment_swapper.sv
// segment_swapper
//   Splits a DATA_W word into NSEG = DATA_W/SEG_W segments and permutes them
//   per beat: pass, pairwise swap, reverse, or rotate-left by rot_amt.
//   There is one registered output stage behind a valid/ready interface.
//   A saturating counter tracks accepted beats whose mode is not pass.
//   Optional feature: define SEGSWAP_PARITY_EN to add out_parity, the even
//   parity of each output segment, registered together with out_data.
//   DATA_W must be a multiple of SEG_W, and NSEG must be even and >= 2.
//
//   Handshake: a beat moves on an edge where valid && ready are both high.
//   in_ready = !out_valid || out_ready, so the single output register can
//   refill in the same cycle that it drains. While out_valid is high and
//   out_ready is low, out_data/out_valid hold and nothing new is accepted.
module segment_swapper #(
  parameter int DATA_W = 32,
  parameter int SEG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_W-1:0]                 in_data,
  input  logic [1:0]                        mode,
  input  logic [$clog2(DATA_W/SEG_W)-1:0]   rot_amt,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_W-1:0]                 out_data,
  input  logic                              cnt_clr,
  output logic [CNT_W-1:0]                  beat_cnt
`ifdef SEGSWAP_PARITY_EN
  ,
  output logic [DATA_W/SEG_W-1:0]           out_parity
`endif
);

  localparam int NSEG = DATA_W / SEG_W;
  // NSEG >= 2 always, so $clog2 is at least 1 here.
  localparam int RW   = (NSEG > 2) ? $clog2(NSEG) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_PAIR = 2'd1,
    MODE_REV  = 2'd2,
    MODE_ROT  = 2'd3
  } mode_e;

  // Source segment that feeds output segment i under mode m.
  // For rotate-left by r: out[(i+r) mod NSEG] = in[i]. Equivalently,
  // out[i] = in[(i - r) mod NSEG]. Adding NSEG keeps the operand positive.
  function automatic int src_seg(input int i, input mode_e m, input int r);
    int s;
    s = i;
    case (m)
      MODE_PASS: s = i;
      MODE_PAIR: s = i ^ 1;
      MODE_REV:  s = NSEG - 1 - i;
      MODE_ROT:  s = (i + NSEG - r) % NSEG;
      default:   s = i;
    endcase
    return s;
  endfunction

  mode_e             mode_sel;
  logic [RW-1:0]     rot_amt_l;
  int                rot_r;
  logic [DATA_W-1:0] perm_data;
  logic              accept;
  logic              cnt_inc;

  logic              out_valid_d, out_valid_q;
  logic [DATA_W-1:0] out_data_d,  out_data_q;
  logic [CNT_W-1:0]  beat_cnt_d,  beat_cnt_q;

  assign mode_sel  = mode_e'(mode);
  assign rot_amt_l = rot_amt;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign cnt_inc   = accept && (mode_sel != MODE_PASS) && (beat_cnt_q != CNT_MAX);

  // Segment permutation of the incoming word. Each output segment is built
  // as a mux over all input segments. Every select index is then a
  // constant, and no variable part-select is needed.
  always_comb begin
    rot_r     = int'(rot_amt_l) % NSEG;
    perm_data = '0;
    for (int i = 0; i < NSEG; i++) begin
      for (int j = 0; j < NSEG; j++) begin
        if (j == src_seg(i, mode_sel, rot_r)) begin
          perm_data[i*SEG_W +: SEG_W] = in_data[j*SEG_W +: SEG_W];
        end
      end
    end
  end

  // Next state for the output register and the permuted-beat counter.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    beat_cnt_d  = beat_cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = perm_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // A clear wins over a same-cycle increment.
    if (cnt_clr) begin
      beat_cnt_d = '0;
    end else if (cnt_inc) begin
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end
  end

  // State registers; a synchronous reset drops any beat that is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      beat_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign beat_cnt  = beat_cnt_q;

`ifdef SEGSWAP_PARITY_EN
  logic [NSEG-1:0] perm_par;
  logic [NSEG-1:0] out_parity_d, out_parity_q;

  // Even-parity bit for each permuted segment.
  always_comb begin
    perm_par = '0;
    for (int i = 0; i < NSEG; i++) begin
      perm_par[i] = ^perm_data[i*SEG_W +: SEG_W];
    end
  end

  // Parity loads on the same accept as out_data and holds otherwise.
  always_comb begin
    out_parity_d = out_parity_q;
    if (accept) begin
      out_parity_d = perm_par;
    end
  end

  // Parity register.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_parity_q <= '0;
    end else begin
      out_parity_q <= out_parity_d;
    end
  end

  assign out_parity = out_parity_q;
`endif

endmodule
